monitor_bus_arbiter: RTL and testbench

//  Lets the SPI monitor become 68000 bus master for DMA-style memory access.

---
 rtl/monitor_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_monitor_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_bus_arbiter.sv
// monitor_bus_arbiter
// Lets the SPI monitor become 68000 bus master. The block runs the BR/BG/BGACK
// handshake against the CPU and grants the bus to the monitor. It also bounds
// how long the monitor waits for a grant and how long it may keep the bus.
module monitor_bus_arbiter #(
  parameter int SYNC_STAGES = 2,     // synchroniser depth for AS/BG/BGACK (>=2)
  parameter int BG_TIMEOUT  = 1024,  // max cycles in REQUEST+WAIT_FREE
  parameter int MAX_TENURE  = 4096,  // max cycles of ownership per grant
  parameter int COOLDOWN    = 16,    // dead time after release (>=1)
  parameter int CNT_W       = 13     // must hold the largest of the limits above
) (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic       RUN_IN,
  input  logic       DMA_REQ_IN,
  input  logic       AS_IN,
  input  logic       BG_IN,
  input  logic       BGACK_IN,
  output logic       BR,
  output logic       BGACK,
  output logic       DMA_GRANT,
  output logic       DMA_TIMEOUT,
  output logic       DMA_EXPIRED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQUEST   = 3'd1,
    S_WAIT_FREE = 3'd2,
    S_OWN       = 3'd3,
    S_RELEASE   = 3'd4,
    S_COOLDOWN  = 3'd5
  } state_t;

  // Terminal counts. Every compare is an equality test against the last
  // allowed count, so the counter always leaves its state before it could wrap.
  localparam logic [CNT_W-1:0] BG_LIMIT     = CNT_W'(BG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TENURE_LIMIT = CNT_W'(MAX_TENURE - 1);
  localparam logic [CNT_W-1:0] COOL_LIMIT   = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Reset and a CPU that is not running have the same effect: everything
  // returns to IDLE and the synchronisers are flushed.
  logic abort;
  assign abort = RESET_IN || !RUN_IN;

  logic [SYNC_STAGES-1:0] as_sync_reg;
  logic [SYNC_STAGES-1:0] bg_sync_reg;
  logic [SYNC_STAGES-1:0] bgack_sync_reg;
  logic                   as_s;
  logic                   bg_s;
  logic                   bgack_s;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_next;
  logic             expired_next;

  logic br_reg;
  logic bgack_reg;
  logic grant_reg;
  logic timeout_reg;
  logic expired_reg;

  // Shift the asynchronous CPU bus signals through the synchroniser chains.
  always_ff @(posedge MCLK_IN) begin
    if (abort) begin
      as_sync_reg    <= '0;
      bg_sync_reg    <= '0;
      bgack_sync_reg <= '0;
    end else begin
      as_sync_reg    <= {as_sync_reg[SYNC_STAGES-2:0], AS_IN};
      bg_sync_reg    <= {bg_sync_reg[SYNC_STAGES-2:0], BG_IN};
      bgack_sync_reg <= {bgack_sync_reg[SYNC_STAGES-2:0], BGACK_IN};
    end
  end

  assign as_s    = as_sync_reg[SYNC_STAGES-1];
  assign bg_s    = bg_sync_reg[SYNC_STAGES-1];
  assign bgack_s = bgack_sync_reg[SYNC_STAGES-1];

  // Next-state, counter and pulse decisions for the handshake.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    expired_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (DMA_REQ_IN) begin
          state_next = S_REQUEST;
        end
      end
      S_REQUEST, S_WAIT_FREE: begin
        // The grant-wait budget spans both states, so the counter is not
        // restarted when BG arrives.
        cnt_next = cnt_reg + CNT_ONE;
        if (!DMA_REQ_IN) begin
          // Withdrawn before the bus was ever ours: no cooldown needed.
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == BG_LIMIT) begin
          // Timeout outranks a grant or a free bus seen in the same cycle.
          state_next   = S_COOLDOWN;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else if (state_reg == S_REQUEST) begin
          if (bg_s) begin
            state_next = S_WAIT_FREE;
          end
        end else if (!as_s && !bgack_s) begin
          // Current cycle finished and no other master holds the bus.
          state_next = S_OWN;
          cnt_next   = '0;
        end
      end
      S_OWN: begin
        cnt_next = cnt_reg + CNT_ONE;
        if (!DMA_REQ_IN) begin
          state_next = S_RELEASE;
        end else if (cnt_reg == TENURE_LIMIT) begin
          state_next   = S_RELEASE;
          expired_next = 1'b1;
        end
      end
      S_RELEASE: begin
        // One cycle with BGACK still held lets the monitor drivers float
        // before the CPU takes the bus back.
        state_next = S_COOLDOWN;
        cnt_next   = '0;
      end
      S_COOLDOWN: begin
        cnt_next = cnt_reg + CNT_ONE;
        if (cnt_reg == COOL_LIMIT) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State register with Moore outputs registered from the next state, so
  // they change on the same edge as STATE.
  always_ff @(posedge MCLK_IN) begin
    if (abort) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      br_reg      <= 1'b0;
      bgack_reg   <= 1'b0;
      grant_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      br_reg      <= (state_next == S_REQUEST) || (state_next == S_WAIT_FREE);
      bgack_reg   <= (state_next == S_OWN) || (state_next == S_RELEASE);
      grant_reg   <= (state_next == S_OWN);
      timeout_reg <= timeout_next;
      expired_reg <= expired_next;
    end
  end

  assign BR          = br_reg;
  assign BGACK       = bgack_reg;
  assign DMA_GRANT   = grant_reg;
  assign DMA_TIMEOUT = timeout_reg;
  assign DMA_EXPIRED = expired_reg;
  assign STATE       = state_reg;

endmodule

// File: tb/tb_monitor_bus_arbiter.sv
// tb_monitor_bus_arbiter
// Two arbiters share one stimulus stream: instance 0 has a long grant
// timeout (64) and instance 1 a short one (8). Both are checked every cycle
// against a timestamp-based model, plus hand-computed expectations.
module tb_monitor_bus_arbiter;

  localparam int SYNC = 2;
  localparam int BGT0 = 64;
  localparam int BGT1 = 8;
  localparam int TEN  = 32;
  localparam int CD   = 16;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_OWN  = 3;
  localparam int P_REL  = 4;
  localparam int P_COOL = 5;

  logic clk = 1'b0;
  logic rst, run, req, as_in, bg_in, bgack_in;
  logic [1:0]      br, bgack, grant, tmo, expd;
  logic [1:0][2:0] st;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    monitor_bus_arbiter #(
      .SYNC_STAGES(SYNC),
      .BG_TIMEOUT (gi == 0 ? BGT0 : BGT1),
      .MAX_TENURE (TEN),
      .COOLDOWN   (CD),
      .CNT_W      (13)
    ) dut (
      .MCLK_IN    (clk),
      .RESET_IN   (rst),
      .RUN_IN     (run),
      .DMA_REQ_IN (req),
      .AS_IN      (as_in),
      .BG_IN      (bg_in),
      .BGACK_IN   (bgack_in),
      .BR         (br[gi]),
      .BGACK      (bgack[gi]),
      .DMA_GRANT  (grant[gi]),
      .DMA_TIMEOUT(tmo[gi]),
      .DMA_EXPIRED(expd[gi]),
      .STATE      (st[gi])
    );
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;  // absolute cycle index used by the model
  int t        = 0;  // test-relative cycle index used by directed checks

  // Model: phase plus the cycle at which its time window opened; elapsed
  // time is a subtraction rather than a counter.
  int m_ph    [2];
  int m_since [2];
  bit m_to    [2];
  bit m_ex    [2];
  bit [SYNC-1:0] h_as [2];
  bit [SYNC-1:0] h_bg [2];
  bit [SYNC-1:0] h_bk [2];

  task automatic chk(input string name, input int inst, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s[%0d] t=%0d actual=%0d required=%0d", name, inst, t, act, expv);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int lim_bg;
      int el;
      int nph;
      bit nto;
      bit nex;
      bit as_s;
      bit bg_s;
      bit bk_s;
      lim_bg = (i == 0) ? BGT0 : BGT1;
      el     = cyc - m_since[i];
      as_s   = h_as[i][SYNC-1];
      bg_s   = h_bg[i][SYNC-1];
      bk_s   = h_bk[i][SYNC-1];
      nph    = m_ph[i];
      nto    = 1'b0;
      nex    = 1'b0;
      if (rst || !run) begin
        nph     = P_IDLE;
        h_as[i] = '0;
        h_bg[i] = '0;
        h_bk[i] = '0;
      end else begin
        case (m_ph[i])
          P_IDLE: begin
            if (req) begin
              nph = P_REQ;
              m_since[i] = cyc + 1;
            end
          end
          P_REQ, P_WAIT: begin
            if (!req) begin
              nph = P_IDLE;
            end else if (el == lim_bg - 1) begin
              nph = P_COOL;
              nto = 1'b1;
              m_since[i] = cyc + 1;
            end else if (m_ph[i] == P_REQ) begin
              if (bg_s) nph = P_WAIT;
            end else if (!as_s && !bk_s) begin
              nph = P_OWN;
              m_since[i] = cyc + 1;
            end
          end
          P_OWN: begin
            if (!req) begin
              nph = P_REL;
            end else if (el == TEN - 1) begin
              nph = P_REL;
              nex = 1'b1;
            end
          end
          P_REL: begin
            nph = P_COOL;
            m_since[i] = cyc + 1;
          end
          P_COOL: begin
            if (el == CD - 1) nph = P_IDLE;
          end
          default: nph = P_IDLE;
        endcase
        h_as[i] = {h_as[i][SYNC-2:0], as_in};
        h_bg[i] = {h_bg[i][SYNC-2:0], bg_in};
        h_bk[i] = {h_bk[i][SYNC-2:0], bgack_in};
      end
      m_ph[i] = nph;
      m_to[i] = nto;
      m_ex[i] = nex;
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("br",      i, int'(br[i]),    int'(m_ph[i] == P_REQ || m_ph[i] == P_WAIT));
      chk("bgack",   i, int'(bgack[i]), int'(m_ph[i] == P_OWN || m_ph[i] == P_REL));
      chk("grant",   i, int'(grant[i]), int'(m_ph[i] == P_OWN));
      chk("timeout", i, int'(tmo[i]),   int'(m_to[i]));
      chk("expired", i, int'(expd[i]),  int'(m_ex[i]));
      chk("state",   i, int'(st[i]),    m_ph[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    t++;
    compare_all();
  endtask

  task automatic goto(input int n);
    while (t < n) tick();
  endtask

  task automatic settle();
    req = 1'b0; as_in = 1'b0; bg_in = 1'b0; bgack_in = 1'b0;
    repeat (4) tick();
    t = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_IDLE; m_since[i] = 0; m_to[i] = 0; m_ex[i] = 0;
      h_as[i] = '0; h_bg[i] = '0; h_bk[i] = '0;
    end
    rst = 1'b1; run = 1'b0; req = 1'b0; as_in = 1'b0; bg_in = 1'b0; bgack_in = 1'b0;
    repeat (3) tick();
    chk("rst_br", 0, int'(br[0]), 0);
    chk("rst_state", 0, int'(st[0]), 0);
    rst = 1'b0; run = 1'b1;
    tick();
    t = 0;

    // Nominal handshake; instance 1 hits its timeout with the bus free (timeout wins).
    req = 1'b1;
    goto(1);  chk("t1_br1", 0, int'(br[0]), 1);
    goto(5);  bg_in = 1'b1;
    goto(8);  chk("t1_wait_state", 0, int'(st[0]), 2);
              chk("t1_no_grant_yet", 0, int'(grant[0]), 0);
    goto(9);  chk("t1_grant", 0, int'(grant[0]), 1);
              chk("t1_bgack", 0, int'(bgack[0]), 1);
              chk("t1_br_fell", 0, int'(br[0]), 0);
              chk("t1_to_pulse", 1, int'(tmo[1]), 1);
              chk("t1_to_state", 1, int'(st[1]), 5);
              chk("t1_to_grant", 1, int'(grant[1]), 0);
    goto(10); chk("t1_to_end", 1, int'(tmo[1]), 0);
    goto(20); req = 1'b0;
    goto(21); chk("t1_rel_grant", 0, int'(grant[0]), 0);
              chk("t1_rel_bgack", 0, int'(bgack[0]), 1);
    goto(22); chk("t1_cool_bgack", 0, int'(bgack[0]), 0);
              chk("t1_cool_state", 0, int'(st[0]), 5);
    goto(37); chk("t1_cool_last", 0, int'(st[0]), 5);
    goto(38); chk("t1_idle", 0, int'(st[0]), 0);
    settle();

    // Bus busy: AS held high after BG, then BGACK_IN held high instead.
    for (int pass = 0; pass < 2; pass++) begin
      req = 1'b1; bg_in = 1'b1;
      if (pass == 0) as_in = 1'b1; else bgack_in = 1'b1;
      goto(10); as_in = 1'b0; bgack_in = 1'b0;
      goto(12); chk("t2_still_wait", 0, int'(st[0]), 2);
                chk("t2_br_held", 0, int'(br[0]), 1);
      goto(13); chk("t2_grant", 0, int'(grant[0]), 1);
      goto(14); req = 1'b0;
      goto(32); chk("t2_idle", 0, int'(st[0]), 0);
      settle();
    end

    // Timeout on instance 1 (BG never asserted); withdraw on instance 0.
    req = 1'b1;
    goto(8);  chk("t3_br_before", 1, int'(br[1]), 1);
              chk("t3_to_before", 1, int'(tmo[1]), 0);
    goto(9);  chk("t3_to_pulse", 1, int'(tmo[1]), 1);
              chk("t3_br_off", 1, int'(br[1]), 0);
              chk("t3_cool", 1, int'(st[1]), 5);
    goto(10); chk("t3_to_end", 1, int'(tmo[1]), 0);
              req = 1'b0;
    goto(11); chk("t6_wd_br", 0, int'(br[0]), 0);
              chk("t6_wd_state", 0, int'(st[0]), 0);
              req = 1'b1;
    goto(12); chk("t6_rereq", 0, int'(br[0]), 1);
              req = 1'b0;
    goto(26);
    settle();

    // Tenure limit with REQ held, then abort by RUN_IN and by RESET_IN.
    req = 1'b1; bg_in = 1'b1;
    goto(3);  chk("t4_pre_grant", 0, int'(grant[0]), 0);
    goto(4);  chk("t4_grant", 0, int'(grant[0]), 1);
    goto(35); chk("t4_grant_last", 0, int'(grant[0]), 1);
    goto(36); chk("t4_grant_off", 0, int'(grant[0]), 0);
              chk("t4_expired", 0, int'(expd[0]), 1);
              chk("t4_expired", 1, int'(expd[1]), 1);
              chk("t4_rel_bgack", 0, int'(bgack[0]), 1);
    goto(37); chk("t4_exp_end", 0, int'(expd[0]), 0);
              chk("t4_cool", 0, int'(st[0]), 5);
    goto(53); chk("t4_idle", 0, int'(st[0]), 0);
              chk("t4_idle_br", 0, int'(br[0]), 0);
    goto(54); chk("t4_new_br", 0, int'(br[0]), 1);
    goto(60); chk("t5_in_own", 0, int'(st[0]), 3);
              run = 1'b0;
    goto(61); chk("t5_run_br", 0, int'(br[0]), 0);
              chk("t5_run_bgack", 0, int'(bgack[0]), 0);
              chk("t5_run_grant", 0, int'(grant[0]), 0);
              chk("t5_run_state", 0, int'(st[0]), 0);
              run = 1'b1;
    goto(65); chk("t5_regrant", 0, int'(grant[0]), 1);
    goto(70); rst = 1'b1;
    goto(71); chk("t5_rst_bgack", 0, int'(bgack[0]), 0);
              chk("t5_rst_grant", 0, int'(grant[0]), 0);
              chk("t5_rst_state", 0, int'(st[0]), 0);
              rst = 1'b0; req = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
